// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver: the receive state encoding, the
// data width of one character, the default bit period and a parity helper.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> frame is 8E1 and the PARITY state exists
//   undefined -> frame is 8N1
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 434;  // 50 MHz / 115200 baud

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd5,
`endif
    ERR    = 3'd4
  } rx_state_e;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer bringing the asynchronous serial line into the clk
// domain. Both flops reset to 1 so an idle (high) line never looks like a
// start bit straight out of reset.
//
// Ports:
//   clk      in   block clock
//   rst_n    in   asynchronous active-low reset
//   i_async  in   raw serial line
//   o_sync   out  synchronized serial line
// -----------------------------------------------------------------------------
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [1:0] r_ff;

  // Synchronizer shift chain: r_ff[0] may go metastable, r_ff[1] is clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff <= 2'b11;
    end else begin
      r_ff <= {r_ff[0], i_async};
    end
  end

  assign o_sync = r_ff[1];

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver, LSB first, one start and one stop bit. The line is sampled
// in the middle of each bit, timed from the centre of the start bit.
//
// Optional feature macro: UART_RX_PARITY_EN (adds one even-parity bit
// between the data bits and the stop bit).
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit, 8..65535
//
// Ports:
//   clk          in   block clock
//   rst_n        in   asynchronous active-low reset
//   i_rxd        in   serial line, asynchronous, idle high
//   i_rx_finish  in   pulse: downstream consumed the data / error
//   o_rx_data    out  received byte in [7:0], [31:8] zero
//   o_rx_num     out  number of bytes received without error (wraps)
//   o_irq        out  level: valid byte waiting in o_rx_data
//   o_busy       out  frame reception in progress (incl. pending error)
//   o_frame_err  out  level: framing or parity error pending
// -----------------------------------------------------------------------------
import uart_pkg::*;

module uart_rx #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rxd,
  input  logic        i_rx_finish,
  output logic [31:0] o_rx_data,
  output logic [31:0] o_rx_num,
  output logic        o_irq,
  output logic        o_busy,
  output logic        o_frame_err
);

  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] CNT_HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]  IDX_LAST = 3'(DATA_BITS - 1);

  logic                 w_rxd_s;
  logic                 w_cnt_last;
  logic                 w_cnt_half;
  logic                 w_par_ok;

  rx_state_e            r_state;
  rx_state_e            w_state_nxt;
  logic [15:0]          r_cnt;
  logic [15:0]          w_cnt_nxt;
  logic [2:0]           r_idx;
  logic [2:0]           w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [DATA_BITS-1:0] r_data;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic [31:0]          r_num;
  logic [31:0]          w_num_nxt;
  logic                 r_irq;
  logic                 w_irq_nxt;
  logic                 r_ferr;
  logic                 w_ferr_nxt;
  logic                 r_busy;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (i_rxd),
    .o_sync  (w_rxd_s)
  );

  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_cnt_half = (r_cnt == CNT_HALF);

`ifdef UART_RX_PARITY_EN
  logic r_par_err;
  logic w_par_err_nxt;

  // Parity result captured at the parity sample point, consumed at stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= w_par_err_nxt;
    end
  end

  assign w_par_ok = ~r_par_err;
`else
  assign w_par_ok = 1'b1;
`endif

  // State and datapath registers; o_busy is registered from the next state
  // so it lines up exactly with the state it reports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 16'd0;
      r_idx   <= 3'd0;
      r_shift <= {DATA_BITS{1'b0}};
      r_data  <= {DATA_BITS{1'b0}};
      r_num   <= 32'd0;
      r_irq   <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_num   <= w_num_nxt;
      r_irq   <= w_irq_nxt;
      r_ferr  <= w_ferr_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  // Next-state and next-value logic for the receive FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_num_nxt   = r_num;
    w_ferr_nxt  = r_ferr;
`ifdef UART_RX_PARITY_EN
    w_par_err_nxt = r_par_err;
`endif
    // A consumer acknowledge clears the interrupt; a byte accepted in the
    // same cycle overrides this below (new data wins).
    if (i_rx_finish) begin
      w_irq_nxt = 1'b0;
    end else begin
      w_irq_nxt = r_irq;
    end

    case (r_state)
      IDLE: begin
        w_cnt_nxt = 16'd0;
        w_idx_nxt = 3'd0;
        if (!w_rxd_s) begin
          w_state_nxt = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      // Re-check the line at mid start bit to reject short low glitches.
      START: begin
        if (w_cnt_half) begin
          w_cnt_nxt = 16'd0;
          if (!w_rxd_s) begin
            w_state_nxt = DATA;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

      // Counter now runs from mid-bit to mid-bit; shift in LSB first.
      DATA: begin
        if (w_cnt_last) begin
          w_cnt_nxt   = 16'd0;
          w_shift_nxt = {w_rxd_s, r_shift[DATA_BITS-1:1]};
          if (r_idx == IDX_LAST) begin
            w_idx_nxt = 3'd0;
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_cnt_last) begin
          w_cnt_nxt     = 16'd0;
          w_par_err_nxt = (w_rxd_s != even_parity(r_shift));
          w_state_nxt   = STOP;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
`endif

      STOP: begin
        if (w_cnt_last) begin
          w_cnt_nxt = 16'd0;
          if (w_rxd_s && w_par_ok) begin
            w_data_nxt  = r_shift;
            w_irq_nxt   = 1'b1;
            w_num_nxt   = r_num + 32'd1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = ERR;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

      // Hold the error until acknowledged; the line is ignored meanwhile.
      ERR: begin
        w_cnt_nxt = 16'd0;
        if (i_rx_finish) begin
          w_ferr_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = ERR;
        end
      end

      default: begin
        w_cnt_nxt   = 16'd0;
        w_idx_nxt   = 3'd0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_rx_data   = {{(32-DATA_BITS){1'b0}}, r_data};
  assign o_rx_num    = r_num;
  assign o_irq       = r_irq;
  assign o_busy      = r_busy;
  assign o_frame_err = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Negedge index (from the start-bit edge) preceding the stop-bit sample
  // edge: 2 sync cycles + 1 to enter START, half a bit, then full bits.
  localparam int ACCEPT_NEG = CPB * (NBITS - 1) + 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_rxd;
  logic        i_rx_finish;
  logic [31:0] o_rx_data;
  logic [31:0] o_rx_num;
  logic        o_irq;
  logic        o_busy;
  logic        o_frame_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (byte-level view of the receiver).
  logic [7:0]  m_data;
  logic        m_irq;
  logic        m_err;
  logic [31:0] m_num;

  typedef struct {
    logic [7:0]  data;
    logic        stop_bit;
    logic        finish_after;
    logic [7:0]  exp_data;
    logic        exp_irq;
    logic        exp_err;
    logic [31:0] exp_num;
  } vec_t;

  vec_t tbl [5];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rxd       (i_rxd),
    .i_rx_finish (i_rx_finish),
    .o_rx_data   (o_rx_data),
    .o_rx_num    (o_rx_num),
    .o_irq       (o_irq),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] d, input logic irq,
                            input logic [31:0] num, input logic busy, input logic err);
    check({tag, ".data"}, o_rx_data, {24'd0, d});
    check({tag, ".irq"},  {31'd0, o_irq}, {31'd0, irq});
    check({tag, ".num"},  o_rx_num, num);
    check({tag, ".busy"}, {31'd0, o_busy}, {31'd0, busy});
    check({tag, ".ferr"}, {31'd0, o_frame_err}, {31'd0, err});
  endtask

  // Drive one frame on i_rxd. par_flip inverts the parity bit (parity
  // builds only). finish_at: negedge index to pulse i_rx_finish (-1 none).
  // abort_at: negedge index to stop driving mid-frame (-1 none).
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                            input int finish_at, input int abort_at);
    logic [NBITS-1:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop_b, (^d) ^ par_flip, d, 1'b0};
`else
    bits = {stop_b, d, 1'b0};
    if (par_flip) bits[0] = 1'b0;
`endif
    for (int k = 0; k < NBITS * CPB; k++) begin
      @(negedge clk);
      i_rxd       = bits[k / CPB];
      i_rx_finish = (k == finish_at);
      if (k == abort_at) return;
    end
    @(negedge clk);
    i_rxd       = 1'b1;
    i_rx_finish = 1'b0;
  endtask

  task automatic pulse_finish();
    @(negedge clk);
    i_rx_finish = 1'b1;
    @(negedge clk);
    i_rx_finish = 1'b0;
  endtask

  // Watchdog: the stimulus below is purely cycle-counted, this only guards
  // against a simulator-level stall.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 32'd1};
    tbl[1] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 32'd2};
    tbl[2] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 32'd3};
    tbl[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 32'd4};
    tbl[4] = '{8'h80, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 32'd4};

    rst_n       = 1'b0;
    i_rxd       = 1'b1;
    i_rx_finish = 1'b0;
    repeat (3) @(negedge clk);
    check_outs("reset", 8'h00, 1'b0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_outs("post_reset", 8'h00, 1'b0, 32'd0, 1'b0, 1'b0);

    // Basic byte, then acknowledge clears the interrupt one cycle later.
    send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
    check_outs("a5", 8'hA5, 1'b1, 32'd1, 1'b0, 1'b0);
    pulse_finish();
    check("a5_ack.irq", {31'd0, o_irq}, 32'd0);

    // 4-cycle low glitch: START is entered, then abandoned without flags.
    @(negedge clk);
    i_rxd = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch.busy_in_start", {31'd0, o_busy}, 32'd1);
    i_rxd = 1'b1;
    repeat (20) @(negedge clk);
    check_outs("glitch", 8'hA5, 1'b0, 32'd1, 1'b0, 1'b0);

    // Table: framing errors, normal bytes, overwrite while irq pending.
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].data, tbl[i].stop_bit, 1'b0, -1, -1);
      check_outs($sformatf("tbl%0d", i), tbl[i].exp_data, tbl[i].exp_irq,
                 tbl[i].exp_num, tbl[i].exp_err, tbl[i].exp_err);
      if (tbl[i].finish_after) begin
        pulse_finish();
        check_outs($sformatf("tbl%0d_ack", i), tbl[i].exp_data, 1'b0,
                   tbl[i].exp_num, 1'b0, 1'b0);
      end
    end

    // Two bytes back to back; acknowledge lands on the second acceptance.
    send_frame(8'h01, 1'b1, 1'b0, -1, -1);
    check_outs("b01", 8'h01, 1'b1, 32'd5, 1'b0, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0, ACCEPT_NEG, -1);
    check_outs("b02_coincident", 8'h02, 1'b1, 32'd6, 1'b0, 1'b0);
    pulse_finish();
    check("b02_ack.irq", {31'd0, o_irq}, 32'd0);
    m_data = 8'h02; m_irq = 1'b0; m_err = 1'b0; m_num = 32'd6;

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so correct even parity bit is 1.
    send_frame(8'h07, 1'b1, 1'b1, -1, -1);
    check_outs("par_bad", 8'h02, 1'b0, 32'd6, 1'b1, 1'b1);
    pulse_finish();
    send_frame(8'h07, 1'b1, 1'b0, -1, -1);
    check_outs("par_good", 8'h07, 1'b1, 32'd7, 1'b0, 1'b0);
    pulse_finish();
    m_data = 8'h07; m_num = 32'd7;
`endif

    // Randomized frames against the byte-level model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      logic       stop_b;
      logic       pflip;
      logic       fin;
      b      = 8'($urandom_range(0, 255));
      stop_b = ($urandom_range(0, 9) != 0);
      fin    = 1'($urandom_range(0, 1));
`ifdef UART_RX_PARITY_EN
      pflip  = ($urandom_range(0, 9) == 0);
`else
      pflip  = 1'b0;
`endif
      send_frame(b, stop_b, pflip, -1, -1);
      if (stop_b && !pflip) begin
        m_data = b;
        m_irq  = 1'b1;
        m_num  = m_num + 32'd1;
      end else begin
        m_err = 1'b1;
      end
      check_outs($sformatf("rnd%0d", i), m_data, m_irq, m_num, m_err, m_err);
      if (m_err || fin) begin
        pulse_finish();
        m_irq = 1'b0;
        m_err = 1'b0;
        check_outs($sformatf("rnd%0d_ack", i), m_data, m_irq, m_num, 1'b0, 1'b0);
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    // Reset in the middle of data bit 4 discards everything immediately.
    send_frame(8'hC3, 1'b1, 1'b0, -1, CPB * 5 + 8);
    check("midrst.busy_before", {31'd0, o_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_outs("midrst", 8'h00, 1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    i_rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h7E, 1'b1, 1'b0, -1, -1);
    check_outs("after_rst", 8'h7E, 1'b1, 32'd1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
